// File: rtl/axi_stream_fifo_pkg.sv
// Shared definitions for the AXI-Lite/stream FIFO IP pair: register word indices,
// CTRL/STATUS bit positions, response codes and a STATUS packing helper.
package axi_stream_fifo_pkg;

   // Register offsets expressed as word indices, i.e. address bits [3:2]
   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_STATUS  = 2'd1;
   localparam logic [1:0] ADDR_CTRL    = 2'd2;
   localparam logic [1:0] ADDR_WORDCNT = 2'd3;

   localparam int CTRL_RX_EN         = 0;
   localparam int CTRL_IRQ_EN        = 1;
   localparam int CTRL_FLUSH         = 2;
   localparam int CTRL_CLR_UNDERFLOW = 3;

   localparam int STAT_EMPTY      = 0;
   localparam int STAT_FULL       = 1;
   localparam int STAT_UNDERFLOW  = 2;
   localparam int STAT_HEAD_TLAST = 3;
   localparam int STAT_OCC_LSB    = 16;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef struct packed {
      logic irq_en;
      logic rx_en;
   } ctrl_t;

   function automatic logic [31:0] pack_status(input logic empty, input logic full,
                                               input logic underflow, input logic head_tlast,
                                               input logic [15:0] occupancy);
      logic [31:0] s;
      s = '0;
      s[STAT_EMPTY]             = empty;
      s[STAT_FULL]              = full;
      s[STAT_UNDERFLOW]         = underflow;
      s[STAT_HEAD_TLAST]        = head_tlast;
      s[STAT_OCC_LSB +: 16]     = occupancy;
      return s;
   endfunction

endpackage

// File: rtl/axi_lite_stream_rx_fifo_if.sv
// Bus bundle for the RX FIFO: AXI4-Lite slave channels plus the AXI4-Stream input.
interface axi_lite_stream_rx_fifo_if #(
   parameter int ADDR_WIDTH  = 4,
   parameter int TDATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]  s00_axi_awaddr;
   logic [2:0]             s00_axi_awprot;
   logic                   s00_axi_awvalid;
   logic                   s00_axi_awready;
   logic [31:0]            s00_axi_wdata;
   logic [3:0]             s00_axi_wstrb;
   logic                   s00_axi_wvalid;
   logic                   s00_axi_wready;
   logic [1:0]             s00_axi_bresp;
   logic                   s00_axi_bvalid;
   logic                   s00_axi_bready;
   logic [ADDR_WIDTH-1:0]  s00_axi_araddr;
   logic [2:0]             s00_axi_arprot;
   logic                   s00_axi_arvalid;
   logic                   s00_axi_arready;
   logic [31:0]            s00_axi_rdata;
   logic [1:0]             s00_axi_rresp;
   logic                   s00_axi_rvalid;
   logic                   s00_axi_rready;
   logic [TDATA_WIDTH-1:0] s_axis_tdata;
   logic                   s_axis_tlast;
   logic                   s_axis_tvalid;
   logic                   s_axis_tready;

   modport slave (
      input  s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
      output s00_axi_awready,
      input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
      output s00_axi_wready,
      output s00_axi_bresp, s00_axi_bvalid,
      input  s00_axi_bready,
      input  s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
      output s00_axi_arready,
      output s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
      input  s00_axi_rready,
      input  s_axis_tdata, s_axis_tlast, s_axis_tvalid,
      output s_axis_tready
   );

   modport master (
      output s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
      input  s00_axi_awready,
      output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
      input  s00_axi_wready,
      input  s00_axi_bresp, s00_axi_bvalid,
      output s00_axi_bready,
      output s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
      input  s00_axi_arready,
      input  s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid,
      output s00_axi_rready,
      output s_axis_tdata, s_axis_tlast, s_axis_tvalid,
      input  s_axis_tready
   );

endinterface

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO shared by the RX and TX stream IPs.
// Flush has priority over any push or pop in the same cycle.
module sync_fwft_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       din,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       dout,
   output logic                   empty,
   output logic                   full,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_push = wr_en & ~full & ~flush;
   assign do_pop  = rd_en & ~empty & ~flush;
   assign empty   = (count == '0);
   assign full    = (count == FULL_COUNT);
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/axi_lite_stream_rx_fifo.sv
// Stream-to-AXI-Lite receive FIFO: AXIS beats are buffered and the CPU pops them
// one at a time by reading the DATA register.
module axi_lite_stream_rx_fifo
   import axi_stream_fifo_pkg::*;
#(
   parameter int C_S00_AXI_DATA_WIDTH = 32,
   parameter int C_S00_AXI_ADDR_WIDTH = 4,
   parameter int C_S_AXIS_TDATA_WIDTH = 32,
   parameter int FIFO_DEPTH           = 16
) (
   input  logic                     s00_axi_aclk,
   input  logic                     s00_axi_aresetn,
   axi_lite_stream_rx_fifo_if.slave bus,
   output logic                     irq_not_empty
);

   localparam int TW = C_S_AXIS_TDATA_WIDTH;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [C_S00_AXI_ADDR_WIDTH-1:0] aw_addr;
   logic [C_S00_AXI_ADDR_WIDTH-1:0] ar_addr;
   logic                            aw_ready_q;
   logic                            b_valid_q;
   logic                            ar_ready_q;
   logic                            r_valid_q;
   logic [C_S00_AXI_DATA_WIDTH-1:0] r_data_q;
   logic [C_S00_AXI_DATA_WIDTH-1:0] rd_word;
   ctrl_t                           ctrl_q;
   logic                            underflow_q;
   logic [31:0]                     word_cnt_q;
   logic                            wr_fire;
   logic                            ctrl_wr;
   logic                            flush_pulse;
   logic                            clr_pulse;
   logic                            rd_fire;
   logic                            pop_data;
   logic                            underflow_set;
   logic                            push;
   logic [TW:0]                     fifo_dout;
   logic                            fifo_empty;
   logic                            fifo_full;
   logic [CW-1:0]                   fifo_count;
   logic                            unused_inputs;

   assign aw_addr = bus.s00_axi_awaddr;
   assign ar_addr = bus.s00_axi_araddr;
   assign unused_inputs = ^{bus.s00_axi_awprot, bus.s00_axi_arprot, bus.s00_axi_wdata,
                            bus.s00_axi_wstrb, aw_addr, ar_addr};

   // AW and W are accepted together; the write lands in the cycle awready is high
   assign wr_fire       = aw_ready_q & bus.s00_axi_awvalid & bus.s00_axi_wvalid;
   assign ctrl_wr       = wr_fire & (aw_addr[3:2] == ADDR_CTRL) & bus.s00_axi_wstrb[0];
   assign flush_pulse   = ctrl_wr & bus.s00_axi_wdata[CTRL_FLUSH];
   assign clr_pulse     = ctrl_wr & bus.s00_axi_wdata[CTRL_CLR_UNDERFLOW];
   assign rd_fire       = ar_ready_q & bus.s00_axi_arvalid;
   assign pop_data      = rd_fire & (ar_addr[3:2] == ADDR_DATA) & ~fifo_empty;
   assign underflow_set = rd_fire & (ar_addr[3:2] == ADDR_DATA) & fifo_empty;

   assign bus.s_axis_tready = ctrl_q.rx_en & ~fifo_full & ~flush_pulse;
   assign push              = bus.s_axis_tvalid & bus.s_axis_tready;

   assign bus.s00_axi_awready = aw_ready_q;
   assign bus.s00_axi_wready  = aw_ready_q;
   assign bus.s00_axi_bvalid  = b_valid_q;
   assign bus.s00_axi_bresp   = RESP_OKAY;
   assign bus.s00_axi_arready = ar_ready_q;
   assign bus.s00_axi_rvalid  = r_valid_q;
   assign bus.s00_axi_rdata   = r_data_q;
   assign bus.s00_axi_rresp   = RESP_OKAY;
   assign irq_not_empty       = ctrl_q.irq_en & ~fifo_empty;

   sync_fwft_fifo #(
      .WIDTH(TW + 1),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk  (s00_axi_aclk),
      .rst_n(s00_axi_aresetn),
      .flush(flush_pulse),
      .wr_en(push),
      .din  ({bus.s_axis_tlast, bus.s_axis_tdata}),
      .rd_en(pop_data),
      .dout (fifo_dout),
      .empty(fifo_empty),
      .full (fifo_full),
      .count(fifo_count)
   );

   // Read mux; head_tlast is masked while empty because the head slot is stale then
   always_comb begin
      rd_word = '0;
      case (ar_addr[3:2])
         ADDR_DATA: begin
            if (!fifo_empty) rd_word[TW-1:0] = fifo_dout[TW-1:0];
         end
         ADDR_STATUS: rd_word = pack_status(fifo_empty, fifo_full, underflow_q,
                                            fifo_dout[TW] & ~fifo_empty, 16'(fifo_count));
         ADDR_CTRL: begin
            rd_word[CTRL_RX_EN]  = ctrl_q.rx_en;
            rd_word[CTRL_IRQ_EN] = ctrl_q.irq_en;
         end
         default: rd_word = word_cnt_q;
      endcase
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         aw_ready_q <= 1'b0;
         b_valid_q  <= 1'b0;
         ctrl_q     <= '0;
      end else begin
         aw_ready_q <= bus.s00_axi_awvalid & bus.s00_axi_wvalid & ~aw_ready_q & ~b_valid_q;
         if (wr_fire)                  b_valid_q <= 1'b1;
         else if (bus.s00_axi_bready)  b_valid_q <= 1'b0;
         if (ctrl_wr) begin
            ctrl_q.rx_en  <= bus.s00_axi_wdata[CTRL_RX_EN];
            ctrl_q.irq_en <= bus.s00_axi_wdata[CTRL_IRQ_EN];
         end
      end
   end

   // One read outstanding: arready cannot pulse again until rvalid has been taken
   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         ar_ready_q  <= 1'b0;
         r_valid_q   <= 1'b0;
         r_data_q    <= '0;
         underflow_q <= 1'b0;
         word_cnt_q  <= '0;
      end else begin
         ar_ready_q <= bus.s00_axi_arvalid & ~ar_ready_q & ~r_valid_q;
         if (rd_fire) begin
            r_valid_q <= 1'b1;
            r_data_q  <= rd_word;
         end else if (bus.s00_axi_rready) begin
            r_valid_q <= 1'b0;
         end
         underflow_q <= (underflow_q & ~clr_pulse) | underflow_set;
         if (push) word_cnt_q <= word_cnt_q + 32'd1;
      end
   end

endmodule

// File: tb/tb_axi_lite_stream_rx_fifo.sv
// Randomised scoreboard bench for the RX FIFO: a queue-based reference model predicts
// every register read and the stream ready, and a monitor compares the DUT responses.
module tb_axi_lite_stream_rx_fifo;
   import axi_stream_fifo_pkg::*;

   localparam int DEPTH = 16;

   logic tb_ACLK = 1'b0;
   logic tb_ARESETN;
   logic irq_not_empty;

   axi_lite_stream_rx_fifo_if #(.ADDR_WIDTH(4), .TDATA_WIDTH(32)) bus ();

   axi_lite_stream_rx_fifo #(
      .C_S00_AXI_DATA_WIDTH(32),
      .C_S00_AXI_ADDR_WIDTH(4),
      .C_S_AXIS_TDATA_WIDTH(32),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .s00_axi_aclk   (tb_ACLK),
      .s00_axi_aresetn(tb_ARESETN),
      .bus            (bus),
      .irq_not_empty  (irq_not_empty)
   );

   always #5 tb_ACLK = ~tb_ACLK;

   int          checks = 0;
   int          errors = 0;
   logic [32:0] model_q[$];
   logic [31:0] exp_q[$];
   logic [32:0] stream_q[$];
   logic        m_rx_en;
   logic        m_irq_en;
   logic        m_underflow;
   logic [31:0] m_word_cnt;
   int          wr_issued;
   int          b_seen;
   int          rx_done = 0;
   logic        beat_taken = 1'b0;
   logic [31:0] last_rdata = '0;

   task automatic report_fail(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
   endtask

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) report_fail(name, act, exp);
      else checks++;
   endtask

   // Reference model: applies the register-map rules to a plain queue once per cycle
   initial forever begin
      logic        wr_fire, ctrl_wr, flush_now, clr_now, exp_ready, uf_set;
      logic [32:0] head;
      logic [31:0] exp_word;
      @(negedge tb_ACLK);
      if (!tb_ARESETN) begin
         model_q.delete();
         exp_q.delete();
         m_rx_en     = 1'b0;
         m_irq_en    = 1'b0;
         m_underflow = 1'b0;
         m_word_cnt  = '0;
         wr_issued   = 0;
         b_seen      = 0;
         beat_taken  = 1'b0;
      end else begin
         wr_fire   = bus.s00_axi_awvalid & bus.s00_axi_awready & bus.s00_axi_wvalid & bus.s00_axi_wready;
         ctrl_wr   = wr_fire && (bus.s00_axi_awaddr[3:2] == ADDR_CTRL) && bus.s00_axi_wstrb[0];
         flush_now = ctrl_wr & bus.s00_axi_wdata[2];
         clr_now   = ctrl_wr & bus.s00_axi_wdata[3];
         exp_ready = m_rx_en && (model_q.size() < DEPTH) && !flush_now;
         check_output("tready", 32'(bus.s_axis_tready), 32'(exp_ready));
         check_output("irq", 32'(irq_not_empty), 32'(m_irq_en && model_q.size() > 0));
         beat_taken = bus.s_axis_tvalid & bus.s_axis_tready;
         uf_set = 1'b0;
         if (bus.s00_axi_arvalid && bus.s00_axi_arready) begin
            case (bus.s00_axi_araddr[3:2])
               ADDR_DATA: begin
                  if (model_q.size() == 0) begin
                     exp_word = '0;
                     uf_set   = 1'b1;
                  end else begin
                     head     = model_q.pop_front();
                     exp_word = head[31:0];
                  end
               end
               ADDR_STATUS: begin
                  exp_word = '0;
                  exp_word[0] = (model_q.size() == 0);
                  exp_word[1] = (model_q.size() == DEPTH);
                  exp_word[2] = m_underflow;
                  if (model_q.size() > 0) begin
                     head = model_q[0];
                     exp_word[3] = head[32];
                  end
                  exp_word[31:16] = 16'(model_q.size());
               end
               ADDR_CTRL: exp_word = {30'd0, m_irq_en, m_rx_en};
               default:   exp_word = m_word_cnt;
            endcase
            exp_q.push_back(exp_word);
         end
         if (bus.s_axis_tvalid && exp_ready) begin
            model_q.push_back({bus.s_axis_tlast, bus.s_axis_tdata});
            m_word_cnt = m_word_cnt + 32'd1;
         end
         if (wr_fire) wr_issued++;
         if (ctrl_wr) begin
            m_rx_en  = bus.s00_axi_wdata[0];
            m_irq_en = bus.s00_axi_wdata[1];
            if (flush_now) model_q.delete();
         end
         m_underflow = (m_underflow & ~clr_now) | uf_set;
      end
   end

   // Monitor: pops the expected response whenever the DUT completes a channel
   initial forever begin
      logic [31:0] exp_word;
      @(negedge tb_ACLK);
      if (tb_ARESETN) begin
         if (bus.s00_axi_bvalid && bus.s00_axi_bready) begin
            if (b_seen >= wr_issued) report_fail("unexpected_bvalid", 32'd1, 32'd0);
            else b_seen++;
            check_output("bresp", 32'(bus.s00_axi_bresp), 32'(RESP_OKAY));
         end
         if (bus.s00_axi_rvalid && bus.s00_axi_rready) begin
            if (exp_q.size() == 0) begin
               report_fail("unexpected_rvalid", bus.s00_axi_rdata, 32'd0);
            end else begin
               exp_word = exp_q.pop_front();
               check_output("rdata", bus.s00_axi_rdata, exp_word);
            end
            check_output("rresp", 32'(bus.s00_axi_rresp), 32'(RESP_OKAY));
            last_rdata = bus.s00_axi_rdata;
            rx_done++;
         end
      end
   end

   // Stream driver: presents the head of stream_q and advances once a beat is taken
   initial forever begin
      logic [32:0] beat;
      @(posedge tb_ACLK);
      #1;
      if (beat_taken && stream_q.size() > 0) void'(stream_q.pop_front());
      beat_taken = 1'b0;
      if (stream_q.size() > 0) begin
         beat = stream_q[0];
         bus.s_axis_tvalid = 1'b1;
         bus.s_axis_tlast  = beat[32];
         bus.s_axis_tdata  = beat[31:0];
      end else begin
         bus.s_axis_tvalid = 1'b0;
      end
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge tb_ACLK);
      #1;
   endtask

   task automatic apply_stimulus(input int n, input logic rand_last);
      for (int i = 0; i < n; i++)
         stream_q.push_back({rand_last ? 1'($urandom_range(0, 1)) : 1'b0, 32'($urandom)});
   endtask

   task automatic axi_write(input logic [1:0] idx, input logic [31:0] data, input logic [3:0] strb);
      int n = 0;
      bus.s00_axi_awaddr  = {idx, 2'b00};
      bus.s00_axi_wdata   = data;
      bus.s00_axi_wstrb   = strb;
      bus.s00_axi_awvalid = 1'b1;
      bus.s00_axi_wvalid  = 1'b1;
      do begin
         @(negedge tb_ACLK);
         n++;
      end while (!bus.s00_axi_awready && n < 50);
      if (!bus.s00_axi_awready) report_fail("aw_timeout", 32'd0, 32'd1);
      @(posedge tb_ACLK);
      #1;
      bus.s00_axi_awvalid = 1'b0;
      bus.s00_axi_wvalid  = 1'b0;
   endtask

   task automatic issue_read(input logic [1:0] idx);
      int n = 0;
      bus.s00_axi_araddr  = {idx, 2'b00};
      bus.s00_axi_arvalid = 1'b1;
      do begin
         @(negedge tb_ACLK);
         n++;
      end while (!bus.s00_axi_arready && n < 50);
      if (!bus.s00_axi_arready) report_fail("ar_timeout", 32'd0, 32'd1);
      @(posedge tb_ACLK);
      #1;
      bus.s00_axi_arvalid = 1'b0;
   endtask

   task automatic read_reg(input logic [1:0] idx);
      int start;
      int n = 0;
      start = rx_done;
      issue_read(idx);
      while (rx_done == start && n < 50) begin
         @(negedge tb_ACLK);
         n++;
      end
      if (rx_done == start) report_fail("r_timeout", 32'd0, 32'd1);
      @(posedge tb_ACLK);
      #1;
   endtask

   task automatic read_check(input logic [1:0] idx, input logic [31:0] exp, input string name);
      read_reg(idx);
      check_output(name, last_rdata, exp);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      tb_ARESETN          = 1'b0;
      bus.s00_axi_awaddr  = '0;
      bus.s00_axi_awprot  = '0;
      bus.s00_axi_awvalid = 1'b0;
      bus.s00_axi_wdata   = '0;
      bus.s00_axi_wstrb   = '0;
      bus.s00_axi_wvalid  = 1'b0;
      bus.s00_axi_bready  = 1'b1;
      bus.s00_axi_araddr  = '0;
      bus.s00_axi_arprot  = '0;
      bus.s00_axi_arvalid = 1'b0;
      bus.s00_axi_rready  = 1'b1;
      bus.s_axis_tdata    = '0;
      bus.s_axis_tlast    = 1'b0;
      bus.s_axis_tvalid   = 1'b0;

      repeat (3) @(posedge tb_ACLK);
      @(negedge tb_ACLK);
      check_output("rst_awready", 32'(bus.s00_axi_awready), 32'd0);
      check_output("rst_bvalid", 32'(bus.s00_axi_bvalid), 32'd0);
      check_output("rst_arready", 32'(bus.s00_axi_arready), 32'd0);
      check_output("rst_rvalid", 32'(bus.s00_axi_rvalid), 32'd0);
      check_output("rst_rdata", bus.s00_axi_rdata, 32'd0);
      check_output("rst_tready", 32'(bus.s_axis_tready), 32'd0);
      check_output("rst_irq", 32'(irq_not_empty), 32'd0);
      @(posedge tb_ACLK);
      #1;
      tb_ARESETN = 1'b1;
      wait_cycles(2);

      // Ordered words, head_tlast visible only once the tlast beat reaches the head
      axi_write(ADDR_CTRL, 32'h1, 4'hF);
      stream_q.push_back({1'b0, 32'h0101FFFF});
      stream_q.push_back({1'b0, 32'habcd0001});
      stream_q.push_back({1'b0, 32'hdead0011});
      stream_q.push_back({1'b1, 32'hbeef0011});
      wait_cycles(8);
      read_check(ADDR_STATUS, 32'h0004_0000, "status_occ4");
      read_check(ADDR_DATA, 32'h0101FFFF, "data0");
      read_check(ADDR_DATA, 32'habcd0001, "data1");
      read_check(ADDR_DATA, 32'hdead0011, "data2");
      read_check(ADDR_STATUS, 32'h0001_0008, "status_head_tlast");
      read_check(ADDR_DATA, 32'hbeef0011, "data3");
      read_check(ADDR_WORDCNT, 32'd4, "wordcnt4");
      read_check(ADDR_STATUS, 32'h0000_0001, "status_empty");

      // Overfill: 16 accepted, then one pop admits exactly one more beat
      apply_stimulus(DEPTH + 3, 1'b0);
      wait_cycles(30);
      read_check(ADDR_STATUS, 32'h0010_0002, "status_full");
      read_check(ADDR_WORDCNT, 32'd20, "wordcnt_full");
      read_reg(ADDR_DATA);
      wait_cycles(5);
      read_check(ADDR_WORDCNT, 32'd21, "wordcnt_one_more");
      read_check(ADDR_STATUS, 32'h0010_0002, "status_refull");

      // Flush with tvalid held: the two pending beats enter only after the flush
      axi_write(ADDR_CTRL, 32'h5, 4'hF);
      wait_cycles(4);
      read_check(ADDR_STATUS, 32'h0002_0000, "status_after_flush");
      read_check(ADDR_WORDCNT, 32'd23, "wordcnt_after_flush");
      read_check(ADDR_CTRL, 32'h1, "ctrl_flush_selfclear");

      // Underflow is sticky until cleared; a byte-0-less strobe leaves CTRL alone
      axi_write(ADDR_CTRL, 32'h0, 4'hF);
      read_reg(ADDR_DATA);
      read_reg(ADDR_DATA);
      read_check(ADDR_DATA, 32'h0, "data_empty");
      read_check(ADDR_STATUS, 32'h0000_0005, "status_underflow");
      axi_write(ADDR_CTRL, 32'h9, 4'hF);
      read_check(ADDR_STATUS, 32'h0000_0001, "status_uf_cleared");
      axi_write(ADDR_CTRL, 32'h3, 4'hE);
      read_check(ADDR_CTRL, 32'h1, "ctrl_strb_ignored");

      // Sustained random traffic with back-to-back, mostly DATA, reads
      axi_write(ADDR_CTRL, 32'h3, 4'hF);
      apply_stimulus(48, 1'b1);
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) read_reg(2'($urandom_range(1, 3)));
         else read_reg(ADDR_DATA);
      end
      apply_stimulus(4, 1'b1);
      wait_cycles(8);

      // Reset while a read response is waiting for rready
      stream_q.delete();
      wait_cycles(2);
      bus.s00_axi_rready = 1'b0;
      issue_read(ADDR_DATA);
      n = 0;
      while (!bus.s00_axi_rvalid && n < 20) begin
         @(negedge tb_ACLK);
         n++;
      end
      if (!bus.s00_axi_rvalid) report_fail("rvalid_pending_timeout", 32'd0, 32'd1);
      @(posedge tb_ACLK);
      #1;
      tb_ARESETN = 1'b0;
      repeat (2) @(posedge tb_ACLK);
      @(negedge tb_ACLK);
      check_output("mid_rst_rvalid", 32'(bus.s00_axi_rvalid), 32'd0);
      check_output("mid_rst_tready", 32'(bus.s_axis_tready), 32'd0);
      check_output("mid_rst_irq", 32'(irq_not_empty), 32'd0);
      @(posedge tb_ACLK);
      #1;
      tb_ARESETN = 1'b1;
      bus.s00_axi_rready = 1'b1;
      wait_cycles(3);
      read_check(ADDR_STATUS, 32'h0000_0001, "post_rst_status");
      read_check(ADDR_CTRL, 32'h0, "post_rst_ctrl");
      read_check(ADDR_WORDCNT, 32'h0, "post_rst_wordcnt");
      wait_cycles(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi_lite_stream_rx_fifo.md
Name: axi_lite_stream_rx_fifo

Overview:
- Receive-direction counterpart to the AXI4-Lite-to-stream FIFO IP.
- Accepts an AXI4-Stream slave input and buffers the words in an internal FIFO.
- Exposes the FIFO to the PS through an AXI4-Lite slave register map, so a CPU read of the DATA register pops one word.
- Sits between PL stream producers and the Zynq GP port. Verified with the same AXI4-Lite master BFM flow as its sibling IP.

Parameters:
- C_S00_AXI_DATA_WIDTH, 32, AXI-Lite data width; only 32 is supported.
- C_S00_AXI_ADDR_WIDTH, 4, AXI-Lite address width; decode uses bits [3:2].
- C_S_AXIS_TDATA_WIDTH, 32, stream data width; must be ≤ 32, and the word is zero-extended on read.
- FIFO_DEPTH, 16, entries; must be a power of 2, range 4..1024.

Ports:
- s00_axi_aclk  in  1  single clock for the whole block
- s00_axi_aresetn  in  1  asynchronous, active-low reset
- s00_axi_awaddr  in  C_S00_AXI_ADDR_WIDTH; s00_axi_awprot in 3 (ignored); s00_axi_awvalid in 1; s00_axi_awready out 1
- s00_axi_wdata  in  32; s00_axi_wstrb in 4; s00_axi_wvalid in 1; s00_axi_wready out 1
- s00_axi_bresp  out  2; s00_axi_bvalid out 1; s00_axi_bready in 1
- s00_axi_araddr  in  C_S00_AXI_ADDR_WIDTH; s00_axi_arprot in 3 (ignored); s00_axi_arvalid in 1; s00_axi_arready out 1
- s00_axi_rdata  out  32; s00_axi_rresp out 2; s00_axi_rvalid out 1; s00_axi_rready in 1
- s_axis_tdata  in  C_S_AXIS_TDATA_WIDTH; s_axis_tlast in 1; s_axis_tvalid in 1; s_axis_tready out 1
- irq_not_empty  out  1  level interrupt: high when FIFO non-empty and CTRL.irq_en=1

Behaviour:
- Reset values: all AXI ready/valid outputs 0, rdata 0, resp 0, s_axis_tready 0, irq 0. FIFO empty, CTRL=0, sticky flags 0, word counter 0.
- Register map:
  - 0x0 DATA (RO): returns the head word; a read pops it.
  - 0x4 STATUS (RO): bit0 empty, bit1 full, bit2 underflow (sticky), bit3 head_tlast, [31:16] occupancy.
  - 0x8 CTRL (RW): bit0 rx_en, bit1 irq_en, bit2 flush (self-clearing, reads 0), bit3 clr_underflow (self-clearing, reads 0).
  - 0xC WORDCNT (RO): total accepted stream beats, 32-bit, wraps modulo 2^32.
- Write channel:
  - awready and wready pulse together for one cycle when awvalid & wvalid & ~awready & ~bvalid.
  - Register update happens on that cycle, honouring wstrb.
  - bvalid rises the next cycle and holds until bready.
  - bresp is always OKAY. Writes to RO addresses are ignored.
- Read channel:
  - arready pulses for one cycle when arvalid & ~arready & ~rvalid; the address is latched.
  - rvalid rises the next cycle with rdata registered and is held until rready. Latency is 1 cycle from the AR handshake.
  - Only one read is outstanding at a time.
- Pop rule:
  - The FIFO pops in the AR handshake cycle when the address is 0x0 and the FIFO is non-empty; the head word is captured into rdata.
  - A DATA read when empty returns 0, sets underflow, and does not pop; rresp is OKAY.
- Stream side:
  - s_axis_tready = rx_en & ~full & ~flush_pulse.
  - On tvalid & tready, {tlast, tdata} is pushed and WORDCNT increments.
- Simultaneous push and pop: occupancy unchanged. A pop from a full FIFO lets tready rise the following cycle (registered full).
- Flush:
  - Occupancy becomes 0 in the cycle after the CTRL write.
  - Any push in that write cycle is blocked by tready=0.
  - A pop racing a flush is discarded.
- clr_underflow together with a new underflow in the same cycle: underflow ends up set (the set wins).
- An async reset asserted mid-transaction drops every outstanding handshake at once; no bvalid/rvalid completes.

Decomposition:
- Shared package axi_stream_fifo_pkg holds:
  - register offsets: ADDR_DATA, ADDR_STATUS, ADDR_CTRL, ADDR_WORDCNT;
  - CTRL/STATUS bit indices;
  - RESP_OKAY.
- Sub-module sync_fwft_fifo, parameterised by width (TDATA_WIDTH+1) and depth, provides dout, empty, full and count. It is shared with the TX sibling IP.

Test Plan:
- CTRL=0x1, then stream 0x0101FFFF, 0xabcd0001, 0xdead0011, 0xbeef0011 (tlast on the last) -> STATUS occupancy=4, head_tlast=0. Four DATA reads return those words in order. WORDCNT=4. A final STATUS reads empty=1, with head_tlast having been 1 just before the last pop.
- Stream FIFO_DEPTH+3 beats with no reads -> tready low after 16 accepted beats; full=1; WORDCNT=16. One DATA read lets exactly one more beat enter.
- DATA read when empty -> rdata=0, STATUS bit2=1. CTRL write 0x9 (rx_en|clr_underflow) -> bit2=0.
- Fill 5 words, write CTRL=0x5 (rx_en|flush) while tvalid is held high -> occupancy 0 next cycle, no beat accepted during the flush cycle, CTRL reads 0x1.
- Sustained tvalid with back-to-back DATA reads -> occupancy stable, no lost or duplicated words (scoreboard check), every bresp/rresp OKAY.
- Assert aresetn low for 2 cycles with rvalid pending -> rvalid=0, FIFO empty, CTRL=0, tready=0 after reset.
